btn_event_decoder: RTL and testbench



---
 rtl/btn_event_decoder.sv | 152 +++++++++++++++
 tb/tb_btn_event_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder
// Turns debounced press/release pulses of one push-button into one-cycle
// single-click, double-click and long-press event pulses. One shared
// counter times both the press duration and the gap between clicks.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int DCLICK_CYCLES = 30_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn_pe,
  input  logic btn_ne,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic pressed
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT2     = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HELD = 3'd4;

  // Last count value before each timeout fires.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  // The button is considered held in any of the press states.
  function automatic logic is_held(input logic [2:0] st);
    is_held = (st == ST_PRESS1) || (st == ST_PRESS2) || (st == ST_LONG_HELD);
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             short_s;
  logic             double_s;
  logic             long_s;
  logic             pe_only_s;
  logic             ne_only_s;
  logic             long_hit_s;
  logic             dclick_hit_s;

  // A simultaneous press and release cannot come from the debouncer, so
  // both are dropped; only exclusive pulses are acted on.
  assign pe_only_s    = btn_pe & ~btn_ne;
  assign ne_only_s    = btn_ne & ~btn_pe;
  assign long_hit_s   = (cnt_r == LONG_LAST);
  assign dclick_hit_s = (cnt_r == DCLICK_LAST);

  // Next-state, event-pulse and counter decode.
  always_comb begin
    state_s  = state_r;
    short_s  = 1'b0;
    double_s = 1'b0;
    long_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pe_only_s) begin
          state_s = ST_PRESS1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS1: begin
        // A release on the threshold edge still counts as a click.
        if (ne_only_s) begin
          state_s = ST_WAIT2;
        end else if (long_hit_s) begin
          state_s = ST_LONG_HELD;
          long_s  = 1'b1;
        end else begin
          state_s = ST_PRESS1;
        end
      end
      ST_WAIT2: begin
        // A second press on the timeout edge wins over the single click.
        if (pe_only_s) begin
          state_s = ST_PRESS2;
        end else if (dclick_hit_s) begin
          state_s = ST_IDLE;
          short_s = 1'b1;
        end else begin
          state_s = ST_WAIT2;
        end
      end
      ST_PRESS2: begin
        // Holding the second press long discards the first click.
        if (ne_only_s) begin
          state_s  = ST_IDLE;
          double_s = 1'b1;
        end else if (long_hit_s) begin
          state_s = ST_LONG_HELD;
          long_s  = 1'b1;
        end else begin
          state_s = ST_PRESS2;
        end
      end
      ST_LONG_HELD: begin
        if (ne_only_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LONG_HELD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Counter restarts on every transition and only runs in timed states,
    // each of which leaves at its threshold, so it can never wrap.
    if (state_s != state_r) begin
      cnt_s = '0;
    end else if ((state_r == ST_PRESS1) || (state_r == ST_WAIT2) ||
                 (state_r == ST_PRESS2)) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs, updated on the transition edge.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      pressed      <= 1'b0;
    end else begin
      short_pulse  <= short_s;
      double_pulse <= double_s;
      long_pulse   <= long_s;
      pressed      <= is_held(state_s);
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed testbench for btn_event_decoder with LONG_CYCLES=20,
// DCLICK_CYCLES=8. Every step drives the inputs for one edge and then
// checks {pressed, short_pulse, double_pulse, long_pulse} just after it.
module tb_btn_event_decoder;

  logic clk;
  logic reset_p;
  logic btn_pe;
  logic btn_ne;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic pressed;

  int vec_count;
  int err_count;
  int step_no;
  string cur_tag;

  localparam logic [3:0] O_NONE = 4'b0000;
  localparam logic [3:0] O_P    = 4'b1000;
  localparam logic [3:0] O_S    = 4'b0100;
  localparam logic [3:0] O_D    = 4'b0010;
  localparam logic [3:0] O_L    = 4'b1001;

  btn_event_decoder #(
    .LONG_CYCLES  (20),
    .DCLICK_CYCLES(8),
    .CNT_W        (27)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .btn_pe      (btn_pe),
    .btn_ne      (btn_ne),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .pressed     (pressed)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_out(input logic [3:0] expv);
    logic [3:0] obs;
    obs = {pressed, short_pulse, double_pulse, long_pulse};
    vec_count++;
    assert (obs === expv) else begin
      err_count++;
      $error("FAIL %s step %0d: observed {p,s,d,l}=%b expected %b",
             cur_tag, step_no, obs, expv);
    end
  endtask

  // Drive inputs for one edge, then check outputs 1 ns after that edge.
  task automatic step(input logic pe, input logic ne, input logic [3:0] expv);
    btn_pe = pe;
    btn_ne = ne;
    @(posedge clk);
    #1;
    btn_pe = 1'b0;
    btn_ne = 1'b0;
    step_no++;
    check_out(expv);
  endtask

  task automatic run(input int n, input logic [3:0] expv);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, expv);
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    step_no   = 0;
    reset_p   = 1'b1;
    btn_pe    = 1'b0;
    btn_ne    = 1'b0;

    cur_tag = "reset";
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out(O_NONE);
    reset_p = 1'b0;
    run(3, O_NONE);

    // Single click: press 5 cycles, short_pulse 8 edges after release.
    cur_tag = "single";
    step(1'b1, 1'b0, O_P);
    run(4, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b0, 1'b0, O_S);
    run(5, O_NONE);

    // Double click: press 4, release 3, press 4, release.
    cur_tag = "double";
    step(1'b1, 1'b0, O_P);
    run(3, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(2, O_NONE);
    step(1'b1, 1'b0, O_P);
    run(3, O_P);
    step(1'b0, 1'b1, O_D);
    run(10, O_NONE);

    // Tie: second press exactly 8 edges after release wins.
    cur_tag = "tie8";
    step(1'b1, 1'b0, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b1, 1'b0, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_D);
    run(10, O_NONE);

    // Gap of 9: short at edge 8, then back-to-back new press.
    cur_tag = "gap9";
    step(1'b1, 1'b0, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b0, 1'b0, O_S);
    step(1'b1, 1'b0, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b0, 1'b0, O_S);
    run(3, O_NONE);

    // Long press: hold 40, long_pulse at edge 20, nothing on release.
    cur_tag = "long";
    step(1'b1, 1'b0, O_P);
    run(19, O_P);
    step(1'b0, 1'b0, O_L);
    run(19, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(10, O_NONE);

    // Release exactly on edge 20: a click, not a long press.
    cur_tag = "rel20";
    step(1'b1, 1'b0, O_P);
    run(19, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b0, 1'b0, O_S);
    run(2, O_NONE);

    // Click then second press held 25: only long_pulse.
    cur_tag = "press2long";
    step(1'b1, 1'b0, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(2, O_NONE);
    step(1'b1, 1'b0, O_P);
    run(19, O_P);
    step(1'b0, 1'b0, O_L);
    run(4, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(12, O_NONE);

    // Simultaneous press and release in IDLE is ignored.
    cur_tag = "both_idle";
    step(1'b1, 1'b1, O_NONE);
    run(3, O_NONE);

    // Simultaneous pulses mid-press are ignored; counter keeps running.
    cur_tag = "both_press";
    step(1'b1, 1'b0, O_P);
    step(1'b1, 1'b1, O_P);
    run(2, O_P);
    step(1'b0, 1'b1, O_NONE);
    run(7, O_NONE);
    step(1'b0, 1'b0, O_S);
    run(2, O_NONE);

    // Asynchronous reset mid-PRESS1 at cnt=10 clears outputs at once.
    cur_tag = "reset_mid";
    step(1'b1, 1'b0, O_P);
    run(10, O_P);
    #2;
    reset_p = 1'b1;
    #1;
    check_out(O_NONE);
    @(posedge clk);
    #1;
    reset_p = 1'b0;
    cur_tag = "post_reset";
    run(30, O_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
